// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with arbitrary (non power-of-two) depth, registered read data,
// occupancy/threshold status and sticky overflow/underflow flags.
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DEPTH         = 10,
  parameter int unsigned AFULL_THRESH  = 8,
  parameter int unsigned AEMPTY_THRESH = 2,
  localparam int unsigned CW           = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_In,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_Out,
  output logic                  data_Valid,
  output logic [CW-1:0]         level,
  output logic                  isEmpty,
  output logic                  isFull,
  output logic                  isAlmostEmpty,
  output logic                  isAlmostFull,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FullLvl = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign rd_acc = enable & read & (level_q != '0);
  assign wr_acc = enable & write & ((level_q != FullLvl) | rd_acc);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    data_out_d   = data_out_q;
    data_valid_d = rd_acc;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d   = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
    end

    if (wr_acc && !rd_acc) begin
      level_d = level_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - 1'b1;
    end

    if (enable && write && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (enable && read && (level_q == '0)) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q] <= data_In;
    end
  end

  assign data_Out      = data_out_q;
  assign data_Valid    = data_valid_q;
  assign level         = level_q;
  assign isEmpty       = (level_q == '0);
  assign isFull        = (level_q == FullLvl);
  assign isAlmostEmpty = (level_q <= CW'(AEMPTY_THRESH));
  assign isAlmostFull  = (level_q >= CW'(AFULL_THRESH));
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule
